// File: rtl/alu_stim_gen.sv
// -----------------------------------------------------------------------------
// alu_stim_gen
//
// Operand/opcode sequencer that feeds the ALU stage through a valid/ready
// handshake. A start pulse sweeps every opcode enabled in op_mask, in
// ascending opcode order. Each opcode gets one of two operand sweeps:
//   - diagonal (mode 0): a = b = 0, 1, ..., 2^WIDTH-1
//   - full     (mode 1): a is the outer loop and b the inner loop, both
//                        running over 0..2^WIDTH-1
// The block counts completed transfers and pulses done when the sweep ends.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   start      begin a sweep (honoured only while idle)
//   mode       0 = diagonal sweep, 1 = full sweep (sampled with start)
//   op_mask    bit k set = opcode k enabled (sampled with start)
//   out_ready  downstream accepts the presented vector this cycle
//   out_valid  a, b and s hold a valid vector
//   a, b       operands
//   s          opcode
//   busy       high while vectors are being issued
//   done       one-cycle pulse when a sweep completes
//   vec_count  transfers completed in the current or last sweep
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module alu_stim_gen #(
  parameter int WIDTH = 5,
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [(1<<OP_W)-1:0]   op_mask,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output logic [OP_W-1:0]        s,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       vec_count
);

  localparam int NUM_OPS = 1 << OP_W;
  localparam logic [WIDTH-1:0] OPND_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q,     state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [OP_W-1:0]    s_q,         s_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [CNT_W-1:0]   vec_count_q, vec_count_d;
  logic               mode_q,      mode_d;
  logic [NUM_OPS-1:0] mask_q,      mask_d;

  // Returns {found, index} of the lowest set bit of vec.
  function automatic logic [OP_W:0] lowest_set(input logic [NUM_OPS-1:0] vec);
    logic [OP_W:0] r;
    r = '0;
    // Scan from the top so that the lowest set bit is the one left in r.
    for (int k = NUM_OPS - 1; k >= 0; k--) begin
      if (vec[k]) begin
        r = {1'b1, OP_W'(k)};
      end
    end
    return r;
  endfunction

  // Enabled opcodes strictly above the current one. The next opcode to
  // sweep is the lowest set bit of this vector.
  logic [NUM_OPS-1:0] higher_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_higher
      assign higher_mask[gi] = mask_q[gi] && (s_q < OP_W'(gi));
    end
  endgenerate

  logic [OP_W:0] first_sel;
  logic [OP_W:0] next_sel;
  logic          first_found;
  logic          next_found;
  logic [OP_W-1:0] first_op;
  logic [OP_W-1:0] next_op;

  assign first_sel   = lowest_set(op_mask);
  assign next_sel    = lowest_set(higher_mask);
  assign first_found = first_sel[OP_W];
  assign first_op    = first_sel[OP_W-1:0];
  assign next_found  = next_sel[OP_W];
  assign next_op     = next_sel[OP_W-1:0];

  // The operand sweep for the current opcode ends on the last vector of
  // the active mode: a at max for the diagonal, a and b both at max for
  // the full sweep.
  logic xfer;
  logic opnd_wrap;

  assign xfer      = out_valid_q && out_ready;
  assign opnd_wrap = mode_q ? ((a_q == OPND_MAX) && (b_q == OPND_MAX))
                            : (a_q == OPND_MAX);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    vec_count_d = vec_count_q;
    mode_d      = mode_q;
    mask_d      = mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          mask_d      = op_mask;
          vec_count_d = '0;
          a_d         = '0;
          b_d         = '0;
          if (first_found) begin
            state_d     = S_RUN;
            s_d         = first_op;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            // No opcode is enabled, so the sweep is empty. out_valid
            // never rises and done follows immediately.
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        if (xfer) begin
          vec_count_d = vec_count_q + CNT_W'(1);
          if (opnd_wrap) begin
            a_d = '0;
            b_d = '0;
            if (next_found) begin
              // The next opcode starts on the very next cycle, so there
              // is no bubble between opcodes.
              s_d = next_op;
            end else begin
              out_valid_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = S_DONE;
            end
          end else if (!mode_q) begin
            a_d = a_q + WIDTH'(1);
            b_d = a_q + WIDTH'(1);
          end else if (b_q == OPND_MAX) begin
            a_d = a_q + WIDTH'(1);
            b_d = '0;
          end else begin
            b_d = b_q + WIDTH'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vec_count_q <= '0;
      mode_q      <= 1'b0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vec_count_q <= vec_count_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign s         = s_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_alu_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_alu_stim_gen
//
// Sweep-level bench for alu_stim_gen. A table of sweep records
// {mode, mask, ready style, expected transfer count} is applied in a loop.
// Each accepted vector is compared against a queue of expected (a, b, s)
// vectors that the bench builds with nested loops. Two hand-written
// sequences cover the reset state and the mid-sweep start/reset case.
// -----------------------------------------------------------------------------
module tb_alu_stim_gen;

  localparam int WIDTH = 5;
  localparam int OP_W  = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [7:0]       op_mask = 8'h00;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  s;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_stim_gen #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .op_mask   (op_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count)
  );

  typedef struct {
    logic       m;
    logic [7:0] mask;
    bit         rnd;
    int         exp_cnt;
  } sweep_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  s;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] lfsr = 8'hA5;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected stream: ascending opcodes; diagonal or a-outer/b-inner operands.
  task automatic build_expected(input logic m, input logic [7:0] mask);
    expq.delete();
    for (int op = 0; op < 8; op++) begin
      if (mask[op]) begin
        if (!m) begin
          for (int i = 0; i < 32; i++)
            expq.push_back('{a: 5'(i), b: 5'(i), s: 3'(op)});
        end else begin
          for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
              expq.push_back('{a: 5'(i), b: 5'(j), s: 3'(op)});
        end
      end
    end
  endtask

  task automatic run_sweep(input logic m, input logic [7:0] mask, input bit rnd,
                           input int exp_cnt);
    exp_t             e;
    int               n = 0;
    int               cyc = 0;
    bit               seen_done = 1'b0;
    bit               stall = 1'b0;
    logic [WIDTH-1:0] pa = '0;
    logic [WIDTH-1:0] pb = '0;
    logic [OP_W-1:0]  ps = '0;

    build_expected(m, mask);
    @(negedge clk);
    start   = 1'b1;
    mode    = m;
    op_mask = mask;
    while (!seen_done && cyc < exp_cnt * 8 + 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      // Latched values must be used; scramble the live inputs.
      mode    = ~m;
      op_mask = ~mask;
      if (rnd) begin
        lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        out_ready = lfsr[0];
      end else begin
        out_ready = 1'b1;
      end
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_a", a, pa);
        check("hold_b", b, pb);
        check("hold_s", s, ps);
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_valid_low", out_valid, 0);
        check("done_busy_low", busy, 0);
        check("done_vec_count", vec_count, exp_cnt);
        check("done_transfers", n, exp_cnt);
        if (!rnd) check("done_latency", cyc, exp_cnt + 1);
      end else if (!rnd && n < exp_cnt) begin
        check("no_gap_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_vector", n + 1, exp_cnt);
        end else begin
          e = expq.pop_front();
          check("vec_a", a, e.a);
          check("vec_b", b, e.b);
          check("vec_s", s, e.s);
          check("vec_count_run", vec_count, n);
          check("busy_run", busy, 1);
        end
        n++;
      end
      stall = out_valid && !out_ready;
      pa = a;
      pb = b;
      ps = s;
    end
    check("done_seen", seen_done, 1);
    @(negedge clk);
    out_ready = 1'b1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    @(negedge clk);
    check("count_hold", vec_count, exp_cnt);
    check("idle_valid_2", out_valid, 0);
    $display("[TB] sweep mode=%0d mask=%02h rnd=%0d transfers=%0d cycles=%0d",
             m, mask, rnd, n, cyc);
  endtask

  sweep_t sweeps[5];

  initial begin
    sweeps[0] = '{m: 1'b0, mask: 8'h01, rnd: 1'b0, exp_cnt: 32};
    sweeps[1] = '{m: 1'b0, mask: 8'h81, rnd: 1'b0, exp_cnt: 64};
    sweeps[2] = '{m: 1'b1, mask: 8'h04, rnd: 1'b0, exp_cnt: 1024};
    sweeps[3] = '{m: 1'b0, mask: 8'h01, rnd: 1'b1, exp_cnt: 32};
    sweeps[4] = '{m: 1'b0, mask: 8'h00, rnd: 1'b0, exp_cnt: 0};

    // Reset held low for three edges.
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", vec_count, 0);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_s", s, 0);
    $display("[TB] reset state checked");
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_valid", out_valid, 0);

    for (int t = 0; t < 5; t++) begin
      run_sweep(sweeps[t].m, sweeps[t].mask, sweeps[t].rnd, sweeps[t].exp_cnt);
    end

    // Mid-sweep: a second start is ignored, then reset aborts the sweep.
    @(negedge clk);
    start     = 1'b1;
    mode      = 1'b0;
    op_mask   = 8'h01;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("mid_a", a, i);
      check("mid_b", b, i);
      check("mid_s", s, 0);
      @(negedge clk);
    end
    check("mid_count10", vec_count, 10);
    start   = 1'b1;
    mode    = 1'b1;
    op_mask = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("mid_ignore_a", a, 11);
    check("mid_ignore_b", b, 11);
    check("mid_ignore_s", s, 0);
    check("mid_ignore_count", vec_count, 11);
    check("mid_ignore_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", vec_count, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    check("mid_rst_idle_valid", out_valid, 0);
    check("mid_rst_idle_busy", busy, 0);
    $display("[TB] mid-sweep start ignored and reset abort checked");

    // A fresh start after the abort begins again at a=b=0.
    run_sweep(1'b0, 8'h01, 1'b0, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
